// File: rtl/led_bcm_scan_ctrl.sv
// HUB75 BCM scan controller: shifts the next row/bit slot while the current one is displayed.
// Optional build macro LEDDRV_ROW_INTERLEAVE_EN: rows run even-ascending then odd-ascending in each plane.
module led_bcm_scan_ctrl #(
  parameter int unsigned CHAIN_WIDTH  = 64,
  parameter int unsigned SCAN_ROWS    = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BASE_CYCLES  = 256,
  parameter int unsigned SCLK_DIV     = 1,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BRIGHT_W     = 8,
  localparam int unsigned COL_W  = (CHAIN_WIDTH > 1) ? $clog2(CHAIN_WIDTH) : 1,
  localparam int unsigned ROW_AW = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1,
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [COL_W-1:0]    col_idx,
  output logic [ROW_AW-1:0]   fetch_row,
  output logic [BIT_W-1:0]    fetch_bit,
  output logic                sclk,
  output logic                latch,
  output logic                oe_n,
  output logic [ROW_AW-1:0]   row_addr,
  output logic                frame_start,
  output logic                busy
);

  localparam int unsigned TMR_W  = $clog2((BASE_CYCLES << (DATA_WIDTH - 1)) + 1);
  localparam int unsigned DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BLK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned PROD_W = TMR_W + BRIGHT_W + 1;

  typedef enum logic [2:0] {SH_OFF, SH_IDLE, SH_REQ, SH_LOW, SH_HIGH, SH_DONE} sh_state_t;
  typedef enum logic [1:0] {DSP_IDLE, DSP_ON, DSP_BLANK, DSP_LATCH} dsp_state_t;

  sh_state_t           r_sh;
  dsp_state_t          r_dsp;
  logic                r_pix_ready, r_sclk, r_latch, r_oe_n, r_frame_start, r_busy;
  logic [COL_W-1:0]    r_col;
  logic [ROW_AW-1:0]   r_fetch_row, r_row_addr;
  logic [BIT_W-1:0]    r_fetch_bit, r_row_bit;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [BLK_W-1:0]    r_blank_cnt;
  logic [TMR_W-1:0]    r_timer;
  logic [BRIGHT_W-1:0] r_bright_q;

  logic [TMR_W-1:0]    w_period, w_timer_nx;
  logic [PROD_W-1:0]   w_on_lim;
  logic                w_expired, w_row_wrap, w_frame_wrap;
  logic [ROW_AW-1:0]   w_next_row;
  logic [BIT_W-1:0]    w_next_bit;

  // Slot period and brightness-scaled on-time for the plane being displayed
  assign w_period   = TMR_W'(BASE_CYCLES) << r_row_bit;
  assign w_on_lim   = ((PROD_W'(r_bright_q) + PROD_W'(1)) * PROD_W'(w_period)) >> BRIGHT_W;
  assign w_expired  = (r_timer == w_period - TMR_W'(1));
  assign w_timer_nx = r_timer + TMR_W'(1);

  // Next slot to shift: rows inner, bit planes outer
  always_comb begin
    w_row_wrap = 1'b0;
    w_next_row = r_fetch_row + ROW_AW'(1);
`ifdef LEDDRV_ROW_INTERLEAVE_EN
    if (32'(r_fetch_row) + 32'd2 < SCAN_ROWS) begin
      w_next_row = r_fetch_row + ROW_AW'(2);
    end else if (!r_fetch_row[0] && SCAN_ROWS > 1) begin
      w_next_row = ROW_AW'(1);
    end else begin
      w_next_row = '0;
      w_row_wrap = 1'b1;
    end
`else
    if (32'(r_fetch_row) == SCAN_ROWS - 1) begin
      w_next_row = '0;
      w_row_wrap = 1'b1;
    end
`endif
    w_next_bit = r_fetch_bit;
    if (w_row_wrap) begin
      w_next_bit = (32'(r_fetch_bit) == DATA_WIDTH - 1) ? '0 : r_fetch_bit + BIT_W'(1);
    end
  end

  assign w_frame_wrap = w_row_wrap && (32'(r_fetch_bit) == DATA_WIDTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= SH_OFF;       r_dsp <= DSP_IDLE;
      r_pix_ready <= 1'b0;  r_sclk <= 1'b0;        r_latch <= 1'b0;
      r_oe_n <= 1'b1;       r_frame_start <= 1'b0; r_busy <= 1'b0;
      r_col <= '0;          r_fetch_row <= '0;     r_fetch_bit <= '0;
      r_row_addr <= '0;     r_row_bit <= '0;       r_div_cnt <= '0;
      r_blank_cnt <= '0;    r_timer <= '0;         r_bright_q <= '0;
    end else if (!enable) begin
      r_sh <= SH_OFF;       r_dsp <= DSP_IDLE;
      r_pix_ready <= 1'b0;  r_sclk <= 1'b0;        r_latch <= 1'b0;
      r_oe_n <= 1'b1;       r_frame_start <= 1'b0; r_busy <= 1'b0;
      r_col <= '0;          r_fetch_row <= '0;     r_fetch_bit <= '0;
      r_row_addr <= '0;     r_row_bit <= '0;       r_div_cnt <= '0;
      r_blank_cnt <= '0;    r_timer <= '0;
    end else begin
      r_frame_start <= 1'b0;
      r_latch       <= 1'b0;

      // The accept cycle in SH_REQ already holds sclk low, so it counts toward the low phase
      case (r_sh)
        SH_OFF: begin
          r_sh   <= SH_IDLE;
          r_busy <= 1'b1;
        end
        SH_IDLE: begin
          r_sh          <= SH_REQ;
          r_pix_ready   <= 1'b1;
          r_frame_start <= 1'b1;
          r_bright_q    <= brightness;
        end
        SH_REQ: begin
          if (pix_valid && r_pix_ready) begin
            r_pix_ready <= 1'b0;
            if (SCLK_DIV <= 1) begin
              r_sh      <= SH_HIGH;
              r_sclk    <= 1'b1;
              r_div_cnt <= '0;
            end else begin
              r_sh      <= SH_LOW;
              r_div_cnt <= DIV_W'(1);
            end
          end
        end
        SH_LOW: begin
          if (32'(r_div_cnt) >= SCLK_DIV - 1) begin
            r_sh      <= SH_HIGH;
            r_sclk    <= 1'b1;
            r_div_cnt <= '0;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        SH_HIGH: begin
          if (32'(r_div_cnt) >= SCLK_DIV - 1) begin
            r_sclk    <= 1'b0;
            r_div_cnt <= '0;
            if (32'(r_col) == CHAIN_WIDTH - 1) begin
              r_col <= '0;
              r_sh  <= SH_DONE;
            end else begin
              r_col       <= r_col + COL_W'(1);
              r_sh        <= SH_REQ;
              r_pix_ready <= 1'b1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        SH_DONE: r_sh <= SH_DONE;
        default: r_sh <= SH_OFF;
      endcase

      // Display side; the latch step also hands the shifter its next slot
      case (r_dsp)
        DSP_IDLE: begin
          r_oe_n <= 1'b1;
          if (r_sh == SH_DONE) begin
            r_dsp       <= DSP_BLANK;
            r_blank_cnt <= '0;
          end
        end
        DSP_ON: begin
          if (w_expired) begin
            r_oe_n <= 1'b1;
            if (r_sh == SH_DONE) begin
              r_dsp       <= DSP_BLANK;
              r_blank_cnt <= '0;
            end
          end else begin
            r_timer <= w_timer_nx;
            r_oe_n  <= !(PROD_W'(w_timer_nx) < w_on_lim);
          end
        end
        DSP_BLANK: begin
          r_oe_n <= 1'b1;
          if (32'(r_blank_cnt) >= BLANK_CYCLES - 1) begin
            r_dsp       <= DSP_LATCH;
            r_latch     <= 1'b1;
            r_row_addr  <= r_fetch_row;
            r_row_bit   <= r_fetch_bit;
            r_timer     <= '0;
            r_sh        <= SH_REQ;
            r_pix_ready <= 1'b1;
            r_fetch_row <= w_next_row;
            r_fetch_bit <= w_next_bit;
            if (w_frame_wrap) begin
              r_frame_start <= 1'b1;
              r_bright_q    <= brightness;
            end
          end else begin
            r_blank_cnt <= r_blank_cnt + BLK_W'(1);
          end
        end
        DSP_LATCH: begin
          r_dsp  <= DSP_ON;
          r_oe_n <= !(PROD_W'(0) < w_on_lim);
        end
        default: r_dsp <= DSP_IDLE;
      endcase
    end
  end

  assign pix_ready   = r_pix_ready;
  assign col_idx     = r_col;
  assign fetch_row   = r_fetch_row;
  assign fetch_bit   = r_fetch_bit;
  assign sclk        = r_sclk;
  assign latch       = r_latch;
  assign oe_n        = r_oe_n;
  assign row_addr    = r_row_addr;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

endmodule

// File: tb/tb_led_bcm_scan_ctrl.sv
// Directed self-checking bench for led_bcm_scan_ctrl (small 4x4, 2-plane configuration).
`timescale 1ns/1ps
module tb_led_bcm_scan_ctrl;

  localparam int unsigned CW = 4, SR = 4, DW = 2, BASE = 8, DIV = 1, BLANK = 2, BW = 8;
  localparam logic [12:0] IDLE_VEC = 13'h0010;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [BW-1:0] brightness = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready, sclk, latch, oe_n, frame_start, busy;
  logic [1:0]    col_idx, fetch_row, row_addr;
  logic          fetch_bit;

  led_bcm_scan_ctrl #(
    .CHAIN_WIDTH(CW), .SCAN_ROWS(SR), .DATA_WIDTH(DW), .BASE_CYCLES(BASE),
    .SCLK_DIV(DIV), .BLANK_CYCLES(BLANK), .BRIGHT_W(BW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .col_idx(col_idx),
    .fetch_row(fetch_row), .fetch_bit(fetch_bit), .sclk(sclk), .latch(latch),
    .oe_n(oe_n), .row_addr(row_addr), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef LEDDRV_ROW_INTERLEAVE_EN
  int row_order [4] = '{0, 2, 1, 3};
`else
  int row_order [4] = '{0, 1, 2, 3};
`endif

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int oe_low = 0;
  logic prev_sclk = 1'b0;
  int rise_cyc[$], fs_cyc[$], latch_cyc[$], latch_row[$], latch_oe[$];
  int lb, fb, rb;

  // Event log: latch_oe[k] holds the oe_n-low cycles between latch k-1 and latch k
  always @(negedge clk) begin
    cyc++;
    if (sclk && !prev_sclk) rise_cyc.push_back(cyc);
    prev_sclk = sclk;
    if (frame_start) fs_cyc.push_back(cyc);
    if (latch) begin
      latch_cyc.push_back(cyc);
      latch_row.push_back(int'(row_addr));
      latch_oe.push_back(oe_low);
      oe_low = 0;
    end else if (!oe_n) begin
      oe_low++;
    end
  end

  function automatic logic [12:0] out_vec();
    return {pix_ready, col_idx, fetch_row, fetch_bit, sclk, latch, oe_n, row_addr, frame_start, busy};
  endfunction

  task automatic wait_latches(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (latch_row.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic mark_bases();
    lb = latch_row.size();
    fb = fs_cyc.size();
    rb = rise_cyc.size();
  endtask

  task automatic restart(input logic [BW-1:0] br);
    rst = 1'b1; enable = 1'b1; pix_valid = 1'b1; brightness = br;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mark_bases();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; pix_valid = 1'b1; brightness = 8'd255;
    repeat (3) @(posedge clk); #1;
    n_total++;
    if (out_vec() !== IDLE_VEC) $display("FAIL reset_values: got %h expected %h", out_vec(), IDLE_VEC);
    else n_pass++;
  endtask

  task automatic test_first_slot();
    bit ok;
    @(negedge clk);
    mark_bases();
    rst = 1'b0;
    wait_latches(lb + 1, 60, ok);
    n_total++;
    if (!ok) begin $display("FAIL first_latch_timeout: got none expected 1 latch"); return; end
    n_pass++;
    // latch seen last cycle, display must be lit now at full brightness
    n_total++;
    if (oe_n !== 1'b0) $display("FAIL first_oe_on: got %b expected 0", oe_n); else n_pass++;
    n_total++;
    if (fs_cyc.size() - fb != 1) $display("FAIL first_fs_count: got %0d expected 1", fs_cyc.size() - fb);
    else n_pass++;
    n_total++;
    if (rise_cyc.size() - rb != 4) begin
      $display("FAIL first_sclk_rises: got %0d expected 4", rise_cyc.size() - rb);
      return;
    end
    n_pass++;
    n_total++;
    if (rise_cyc[rb] - fs_cyc[fb] != 1) $display("FAIL fs_to_first_rise: got %0d expected 1", rise_cyc[rb] - fs_cyc[fb]);
    else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_total++;
      if (rise_cyc[rb+i] - rise_cyc[rb+i-1] != 2)
        $display("FAIL sclk_gap%0d: got %0d expected 2", i, rise_cyc[rb+i] - rise_cyc[rb+i-1]);
      else n_pass++;
    end
    // last high phase, one done cycle, then two blank cycles before the latch
    n_total++;
    if (latch_cyc[lb] - rise_cyc[rb+3] != 4)
      $display("FAIL rise_to_latch: got %0d expected 4", latch_cyc[lb] - rise_cyc[rb+3]);
    else n_pass++;
    n_total++;
    if (latch_row[lb] != 0) $display("FAIL first_row_addr: got %0d expected 0", latch_row[lb]);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    bit ok;
    int n_fs;
    wait_latches(lb + 9, 400, ok);
    n_total++;
    if (!ok) begin $display("FAIL frame_timeout: got %0d expected 9 latches", latch_row.size() - lb); return; end
    n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (latch_row[lb+k] != row_order[k%4])
        $display("FAIL frame_row%0d: got %0d expected %0d", k, latch_row[lb+k], row_order[k%4]);
      else n_pass++;
      n_total++;
      if (latch_oe[lb+k+1] != ((k < 4) ? 8 : 16))
        $display("FAIL frame_ontime%0d: got %0d expected %0d", k, latch_oe[lb+k+1], (k < 4) ? 8 : 16);
      else n_pass++;
    end
    n_fs = 0;
    foreach (fs_cyc[i]) if (i >= fb && fs_cyc[i] <= latch_cyc[lb+7]) n_fs++;
    n_total++;
    if (n_fs != 2) $display("FAIL frame_fs_count: got %0d expected 2", n_fs); else n_pass++;
    n_total++;
    if (fs_cyc[fb+1] != latch_cyc[lb+7])
      $display("FAIL frame_fs_timing: got cyc %0d expected %0d", fs_cyc[fb+1], latch_cyc[lb+7]);
    else n_pass++;
  endtask

  task automatic test_brightness();
    bit ok;
    int exp_on [9] = '{4, 4, 4, 4, 8, 8, 8, 16, 8};
    restart(8'd127);
    wait_latches(lb + 3, 200, ok);
    brightness = 8'd255;
    wait_latches(lb + 10, 500, ok);
    n_total++;
    if (!ok) begin $display("FAIL bright_timeout: got %0d expected 10 latches", latch_row.size() - lb); return; end
    n_pass++;
    // slot 7 is latched together with the next frame_start, so it already uses the new value
    for (int k = 0; k < 9; k++) begin
      n_total++;
      if (latch_oe[lb+k+1] != exp_on[k])
        $display("FAIL bright_ontime%0d: got %0d expected %0d", k, latch_oe[lb+k+1], exp_on[k]);
      else n_pass++;
    end
  endtask

  task automatic test_dim();
    bit ok;
    restart(8'd0);
    wait_latches(lb + 6, 300, ok);
    n_total++;
    if (!ok) begin $display("FAIL dim_timeout: got %0d expected 6 latches", latch_row.size() - lb); return; end
    n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (latch_oe[lb+k+1] != 0) $display("FAIL dim_ontime%0d: got %0d expected 0", k, latch_oe[lb+k+1]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    int bad, rel;
    restart(8'd255);
    wait_latches(lb + 1, 60, ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pix_ready === 1'b1 && col_idx === 2'd2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_total++;
    if (!ok) begin $display("FAIL stall_reach_col2: got col %0d expected 2", col_idx); return; end
    n_pass++;
    pix_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sclk !== 1'b0 || pix_ready !== 1'b1 || col_idx !== 2'd2) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL stall_frozen: got %0d bad cycles expected 0", bad); else n_pass++;
    n_total++;
    if (oe_n !== 1'b1) $display("FAIL stall_oe_blank: got %b expected 1", oe_n); else n_pass++;
    n_total++;
    if (latch_row.size() != lb + 1) $display("FAIL stall_no_latch: got %0d expected %0d", latch_row.size(), lb + 1);
    else n_pass++;
    rel = cyc;
    pix_valid = 1'b1;
    wait_latches(lb + 2, 60, ok);
    n_total++;
    if (!ok) begin $display("FAIL stall_resume_timeout: got none expected latch"); return; end
    n_pass++;
    // cols 2..3 finish in 4 cycles, then done, 2 blank, latch
    n_total++;
    if (latch_cyc[lb+1] - rel != 8) $display("FAIL stall_resume_delay: got %0d expected 8", latch_cyc[lb+1] - rel);
    else n_pass++;
    n_total++;
    if (latch_row[lb+1] != row_order[1]) $display("FAIL stall_row: got %0d expected %0d", latch_row[lb+1], row_order[1]);
    else n_pass++;
    n_total++;
    if (latch_oe[lb+1] != 8) $display("FAIL stall_ontime: got %0d expected 8", latch_oe[lb+1]); else n_pass++;
  endtask

  task automatic test_enable_drop();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sclk === 1'b1 && oe_n === 1'b0) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok) begin $display("FAIL drop_find_window: got none expected sclk=1 oe_n=0"); return; end
    n_pass++;
    enable = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (out_vec() !== IDLE_VEC) $display("FAIL drop_idle: got %h expected %h", out_vec(), IDLE_VEC); else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_total++;
    if (out_vec() !== IDLE_VEC) $display("FAIL drop_hold: got %h expected %h", out_vec(), IDLE_VEC); else n_pass++;
    mark_bases();
    enable = 1'b1;
    wait_latches(lb + 1, 60, ok);
    n_total++;
    if (!ok) begin $display("FAIL reenable_timeout: got none expected latch"); return; end
    n_pass++;
    n_total++;
    if (fs_cyc.size() - fb != 1) $display("FAIL reenable_fs: got %0d expected 1", fs_cyc.size() - fb); else n_pass++;
    n_total++;
    if (latch_row[lb] != 0) $display("FAIL reenable_row: got %0d expected 0", latch_row[lb]); else n_pass++;
  endtask

  task automatic test_async_reset();
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (out_vec() !== IDLE_VEC) $display("FAIL async_reset: got %h expected %h", out_vec(), IDLE_VEC); else n_pass++;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_first_slot();
    test_full_frame();
    test_brightness();
    test_dim();
    test_stall();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
